// File: rtl/vm_pkg.sv
// Shared constants and types for the vending machine front end.
package vm_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20000;
  localparam int unsigned COIN_W = 5;

  localparam logic [COIN_W-1:0] COIN_1  = 5'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
  localparam logic [COIN_W-1:0] COIN_20 = 5'd20;

  typedef enum logic {
    CS_IDLE,
    CS_LOCKED
  } coin_state_e;

  // Highest-index closed switch wins when several are closed at once.
  function automatic logic [COIN_W-1:0] coin_value_of(input logic [3:0] sw);
    if (sw[3]) return COIN_20;
    if (sw[2]) return COIN_10;
    if (sw[1]) return COIN_5;
    if (sw[0]) return COIN_1;
    return '0;
  endfunction

endpackage

// File: rtl/vm_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw input bit.
module vm_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             synced_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles to be accepted.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = synced_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q   <= 1'b0;
      synced_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      synced_q <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/vm_input_conditioner.sv
// Turns raw buttons and coin switches into clean one-cycle events for the controller.
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              L_button,
  input  logic              R_button,
  input  logic              C_button,
  input  logic [3:0]        switch,
  input  logic              credit_full,
  output logic              l_pulse,
  output logic              r_pulse,
  output logic              c_pulse,
  output logic              coin_valid,
  output logic [COIN_W-1:0] coin_value
);

  logic [6:0] raw;
  logic [6:0] stable;

  assign raw = {switch, C_button, R_button, L_button};

  for (genvar i = 0; i < 7; i++) begin : g_db
    vm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (raw[i]),
      .stable_o(stable[i])
    );
  end

  logic [2:0]        btn_prev_q;
  logic [2:0]        btn_rise;
  logic [2:0]        pulse_q, pulse_d;
  logic [3:0]        sw_stable;
  coin_state_e       state_q, state_d;
  logic              coin_valid_q, coin_valid_d;
  logic [COIN_W-1:0] coin_value_q, coin_value_d;

  assign btn_rise  = stable[2:0] & ~btn_prev_q;
  assign sw_stable = stable[6:3];

  // L and R rising together cancel each other; C is unaffected.
  always_comb begin
    pulse_d    = '0;
    pulse_d[0] = btn_rise[0] & ~btn_rise[1];
    pulse_d[1] = btn_rise[1] & ~btn_rise[0];
    pulse_d[2] = btn_rise[2];
  end

  always_comb begin
    state_d      = state_q;
    coin_valid_d = 1'b0;
    coin_value_d = '0;
    unique case (state_q)
      CS_IDLE: begin
        if ((sw_stable != 4'b0000) && !credit_full) begin
          coin_valid_d = 1'b1;
          coin_value_d = coin_value_of(sw_stable);
          state_d      = CS_LOCKED;
        end
      end
      CS_LOCKED: begin
        if (sw_stable == 4'b0000) begin
          state_d = CS_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q   <= '0;
      pulse_q      <= '0;
      state_q      <= CS_IDLE;
      coin_valid_q <= 1'b0;
      coin_value_q <= '0;
    end else begin
      btn_prev_q   <= stable[2:0];
      pulse_q      <= pulse_d;
      state_q      <= state_d;
      coin_valid_q <= coin_valid_d;
      coin_value_q <= coin_value_d;
    end
  end

  assign l_pulse    = pulse_q[0];
  assign r_pulse    = pulse_q[1];
  assign c_pulse    = pulse_q[2];
  assign coin_valid = coin_valid_q;
  assign coin_value = coin_value_q;

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Scenario bench for vm_input_conditioner with a sample-window reference model.
module tb_vm_input_conditioner;

  localparam int D    = 4;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       L_button, R_button, C_button, credit_full;
  logic [3:0] switch;
  logic       l_pulse, r_pulse, c_pulse, coin_valid;
  logic [4:0] coin_value;

  vm_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .L_button   (L_button),
    .R_button   (R_button),
    .C_button   (C_button),
    .switch     (switch),
    .credit_full(credit_full),
    .l_pulse    (l_pulse),
    .r_pulse    (r_pulse),
    .c_pulse    (c_pulse),
    .coin_valid (coin_valid),
    .coin_value (coin_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = -1;

  // Per-edge history: raw value as seen by the synchroniser, and accepted level.
  logic [6:0] raw_h[MAXE];
  logic [6:0] stb_h[MAXE];
  bit         locked = 1'b0;
  logic       exp_l, exp_r, exp_c, exp_cv;
  logic [4:0] exp_val;

  function automatic logic [4:0] max_coin(input logic [3:0] sw);
    int w[4] = '{1, 5, 10, 20};
    int v = 0;
    for (int i = 0; i < 4; i++) if (sw[i] && w[i] > v) v = w[i];
    return 5'(v);
  endfunction

  // Advance one clock edge and update the reference model with the sampled inputs.
  task automatic tick();
    logic [6:0] p1, p2;
    logic [2:0] rise;
    logic [3:0] sw;
    bit         flip;
    logic       v;
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget: reached %0d edges, limit %0d", edge_n, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    if (rst) begin
      raw_h[edge_n] = '0;
      if (edge_n >= 1) raw_h[edge_n-1] = '0;
      stb_h[edge_n] = '0;
      {exp_l, exp_r, exp_c, exp_cv} = '0;
      exp_val = '0;
      locked  = 1'b0;
    end else begin
      p1 = (edge_n >= 1) ? stb_h[edge_n-1] : '0;
      p2 = (edge_n >= 2) ? stb_h[edge_n-2] : '0;
      raw_h[edge_n] = {switch, C_button, R_button, L_button};
      for (int i = 0; i < 7; i++) begin
        flip = 1'b1;
        for (int k = edge_n - 1 - D; k <= edge_n - 2; k++) begin
          v = (k >= 0) ? raw_h[k][i] : 1'b0;
          if (v == p1[i]) flip = 1'b0;
        end
        stb_h[edge_n][i] = flip ? ~p1[i] : p1[i];
      end
      rise  = p1[2:0] & ~p2[2:0];
      exp_l = rise[0] & ~rise[1];
      exp_r = rise[1] & ~rise[0];
      exp_c = rise[2];
      sw    = p1[6:3];
      exp_cv  = 1'b0;
      exp_val = '0;
      if (!locked && sw != 4'b0000 && !credit_full) begin
        exp_cv  = 1'b1;
        exp_val = max_coin(sw);
        locked  = 1'b1;
      end else if (locked && sw == 4'b0000) begin
        locked = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !== 9'd0) begin
        $display("FAIL reset_outputs edge %0d: got %b%b%b%b val %0d, want all 0",
                 edge_n, l_pulse, r_pulse, c_pulse, coin_valid, coin_value);
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_l();
    int first = -1, nl = 0, nrc = 0;
    for (int t = 1; t <= 32; t++) begin
      L_button = (t <= 20);
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
          {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
        $display("FAIL model_clean_l edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                 l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                 exp_l, exp_r, exp_c, exp_cv, exp_val);
      end else n_pass++;
      if (l_pulse) begin nl++; if (first < 0) first = t; end
      nrc += int'(r_pulse) + int'(c_pulse);
    end
    n_checks++;
    if (nl !== 1 || first !== 7) begin
      $display("FAIL clean_l_pulse: got %0d pulses first at edge %0d, want 1 at edge 7", nl, first);
    end else n_pass++;
    n_checks++;
    if (nrc !== 0) $display("FAIL clean_l_others: got %0d r/c pulses, want 0", nrc);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int first = -1, nc = 0;
    for (int t = 1; t <= 42; t++) begin
      if (t <= 12) C_button = (((t - 1) / 2) % 2 == 0);
      else C_button = (t <= 30);
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
          {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
        $display("FAIL model_bounce edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                 l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                 exp_l, exp_r, exp_c, exp_cv, exp_val);
      end else n_pass++;
      if (c_pulse) begin nc++; if (first < 0) first = t; end
    end
    n_checks++;
    if (nc !== 1 || first !== 19) begin
      $display("FAIL bounce_c_pulse: got %0d pulses first at %0d, want 1 at 19", nc, first);
    end else n_pass++;
  endtask

  task automatic test_lr_simul();
    logic [1:0] lr[4] = '{2'b11, 2'b00, 2'b10, 2'b00};
    int         t = 0, nl = 0, nr = 0, first_r = -1;
    for (int p = 0; p < 4; p++) begin
      {R_button, L_button} = lr[p];
      for (int j = 0; j < 15; j++) begin
        tick();
        t++;
        n_checks++;
        if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
            {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
          $display("FAIL model_lr edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                   l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                   exp_l, exp_r, exp_c, exp_cv, exp_val);
        end else n_pass++;
        nl += int'(l_pulse);
        if (r_pulse) begin nr++; if (first_r < 0) first_r = t; end
      end
    end
    n_checks++;
    if (nl !== 0) $display("FAIL lr_no_l_pulse: got %0d l pulses, want 0", nl);
    else n_pass++;
    n_checks++;
    if (nr !== 1 || first_r !== 37) begin
      $display("FAIL lr_r_only: got %0d r pulses first at %0d, want 1 at 37", nr, first_r);
    end else n_pass++;
  endtask

  task automatic test_coin();
    logic [3:0] seq[5] = '{4'b1010, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    int         len[5] = '{30, 15, 15, 20, 12};
    int         ev_t[$];
    logic [4:0] ev_v[$];
    int         t = 0;
    for (int p = 0; p < 5; p++) begin
      switch = seq[p];
      for (int j = 0; j < len[p]; j++) begin
        tick();
        t++;
        n_checks++;
        if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
            {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
          $display("FAIL model_coin edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                   l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                   exp_l, exp_r, exp_c, exp_cv, exp_val);
        end else n_pass++;
        if (coin_valid) begin ev_t.push_back(t); ev_v.push_back(coin_value); end
      end
    end
    n_checks++;
    if (ev_t.size() !== 2) begin
      $display("FAIL coin_event_count: got %0d events, want 2", ev_t.size());
    end else begin
      n_pass++;
      n_checks++;
      if (ev_t[0] !== 7 || ev_v[0] !== 5'd20)
        $display("FAIL coin_priority: got value %0d at %0d, want 20 at 7", ev_v[0], ev_t[0]);
      else n_pass++;
      n_checks++;
      if (ev_t[1] !== 67 || ev_v[1] !== 5'd1)
        $display("FAIL coin_after_lock: got value %0d at %0d, want 1 at 67", ev_v[1], ev_t[1]);
      else n_pass++;
    end
  endtask

  task automatic test_credit_full();
    int         nev = 0, first = -1;
    logic [4:0] val = '0;
    credit_full = 1'b1;
    switch      = 4'b0100;
    for (int t = 1; t <= 40; t++) begin
      if (t == 17) credit_full = 1'b0;
      if (t == 26) switch = 4'b0000;
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
          {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
        $display("FAIL model_credit edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                 l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                 exp_l, exp_r, exp_c, exp_cv, exp_val);
      end else n_pass++;
      if (coin_valid) begin nev++; if (first < 0) begin first = t; val = coin_value; end end
    end
    n_checks++;
    if (nev !== 1 || first !== 17 || val !== 5'd10) begin
      $display("FAIL credit_gate: got %0d events first at %0d value %0d, want 1 at 17 value 10",
               nev, first, val);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nl = 0, first = -1;
    L_button = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      nl += int'(l_pulse);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !== 9'd0) begin
      $display("FAIL reset_mid_outputs: got %b%b%b%b val %0d, want all 0",
               l_pulse, r_pulse, c_pulse, coin_valid, coin_value);
    end else n_pass++;
    rst = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 16) L_button = 1'b0;
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
          {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
        $display("FAIL model_reset_mid edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                 l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                 exp_l, exp_r, exp_c, exp_cv, exp_val);
      end else n_pass++;
      if (l_pulse) begin nl++; if (first < 0) first = t; end
    end
    n_checks++;
    if (nl !== 1 || first !== 7) begin
      $display("FAIL reset_mid_l_pulse: got %0d pulses first at %0d, want 1 at 7", nl, first);
    end else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 4) == 0) L_button = ~L_button;
      if ($urandom_range(0, 4) == 0) R_button = ~R_button;
      if ($urandom_range(0, 4) == 0) C_button = ~C_button;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) switch[b] = ~switch[b];
      if ($urandom_range(0, 9) == 0) credit_full = ~credit_full;
      rst = ($urandom_range(0, 149) == 0);
      tick();
      n_checks++;
      if ({l_pulse, r_pulse, c_pulse, coin_valid, coin_value} !==
          {exp_l, exp_r, exp_c, exp_cv, exp_val}) begin
        $display("FAIL model_random edge %0d: got %b%b%b%b/%0d want %b%b%b%b/%0d", edge_n,
                 l_pulse, r_pulse, c_pulse, coin_valid, coin_value,
                 exp_l, exp_r, exp_c, exp_cv, exp_val);
      end else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MAXE; i++) begin
      raw_h[i] = '0;
      stb_h[i] = '0;
    end
    rst         = 1'b1;
    L_button    = 1'b0;
    R_button    = 1'b0;
    C_button    = 1'b0;
    switch      = 4'b0000;
    credit_full = 1'b0;
    test_reset();
    test_clean_l();
    test_bounce();
    test_lr_simul();
    test_coin();
    test_credit_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
